// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM read-streaming stages.
// Holds the streamer FSM state encoding and the output buffer depth.
// No logic; imported by ram_read_streamer and stream_fifo2.
package ram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_e;

   // Output buffer depth and the width of its occupancy counter (0..DEPTH).
   localparam int BUF_DEPTH = 2;
   localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO of {last, data} words for valid/ready stream stages.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same
// cycle; pop is ignored when empty. Ports: push/push_dat in, pop in,
// head_dat/count out.
module stream_fifo2
   import ram_stream_pkg::*;
#(
   parameter int WIDTH = 11
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_dat,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head_dat,
   output logic [BUF_CNT_W-1:0] count
);

   logic [1:0][WIDTH-1:0]  mem_q, mem_d;
   logic                   wr_ptr_q, wr_ptr_d;
   logic                   rd_ptr_q, rd_ptr_d;
   logic [BUF_CNT_W-1:0]   count_q, count_d;
   logic                   full, empty, do_push, do_pop;

   assign full    = (count_q == BUF_CNT_W'(BUF_DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees the slot the push is about to use.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + BUF_CNT_W'(1);
         2'b01:   count_d = count_q - BUF_CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/ram_read_streamer.sv
// Burst reader: walks a combinational RAM read port one address per cycle
// and streams the words out through a 2-entry buffer with a last flag.
// Latency: first word valid 2 cycles after the command handshake; 1 word/cycle.
// Backpressure: reads stop while the buffer is full; commands are held off
// (cmd_ready=0) until the previous burst's last beat has been accepted.
// Ports: cmd_* command in, s_read_* RAM port, m_* stream out, busy/cmd_done.
module ram_read_streamer
   import ram_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 10,
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  s_read_req,
   output logic [ADDR_WIDTH-1:0] s_read_addr,
   input  logic [DATA_WIDTH-1:0] s_read_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  cmd_done
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  remain_q, remain_d;
   logic                  cmd_done_q, cmd_done_d;

   logic [BUF_CNT_W-1:0]  buf_count;
   logic [DATA_WIDTH:0]   buf_head;
   logic                  issue, is_last, pop;

   // Issue depends only on registered state and the registered buffer count,
   // so m_ready never reaches the RAM address/strobe combinationally.
   assign issue   = (state_q == STREAM) && (buf_count < BUF_CNT_W'(BUF_DEPTH));
   assign is_last = (remain_q == LEN_WIDTH'(1));
   assign pop     = m_valid & m_ready;

   stream_fifo2 #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .push     (issue),
      .push_dat ({is_last, s_read_data}),
      .pop      (pop),
      .head_dat (buf_head),
      .count    (buf_count)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      cmd_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d   = cmd_addr;
               remain_d = cmd_len;
               if (cmd_len == '0) begin
                  cmd_done_d = 1'b1;
               end else begin
                  state_d = STREAM;
               end
            end
         end
         STREAM: begin
            if (issue) begin
               addr_d   = addr_q + ADDR_WIDTH'(1);
               remain_d = remain_q - LEN_WIDTH'(1);
               if (is_last) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Only the beat tagged last can pop here with m_last set.
            if (pop && m_last) begin
               state_d    = IDLE;
               cmd_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         cmd_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         cmd_done_q <= cmd_done_d;
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign s_read_req  = issue;
   assign s_read_addr = addr_q;
   assign m_valid     = (buf_count != '0);
   assign m_data      = buf_head[DATA_WIDTH-1:0];
   assign m_last      = m_valid & buf_head[DATA_WIDTH];
   assign busy        = (state_q != IDLE) || (buf_count != '0);
   assign cmd_done    = cmd_done_q;

endmodule

// File: tb/tb_ram_read_streamer.sv
module tb_ram_read_streamer;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [11:0] cmd_addr;
   logic [11:0] cmd_len;
   logic        s_read_req;
   logic [11:0] s_read_addr;
   logic [9:0]  s_read_data;
   logic        m_valid;
   logic        m_ready;
   logic [9:0]  m_data;
   logic        m_last;
   logic        busy;
   logic        cmd_done;

   logic [9:0]  mem [4096];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign s_read_data = mem[s_read_addr];

   ram_read_streamer #(
      .DATA_WIDTH (10),
      .ADDR_WIDTH (12),
      .LEN_WIDTH  (12)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_len     (cmd_len),
      .s_read_req  (s_read_req),
      .s_read_addr (s_read_addr),
      .s_read_data (s_read_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .busy        (busy),
      .cmd_done    (cmd_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Offer a command at the next falling edge (one cycle after any previous
   // completion, so the done pulse must already have dropped).
   task automatic offer(input logic [11:0] addr, input int len);
      @(negedge clk);
      chk("done_single_pulse", 32'(cmd_done), 32'd0);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = 12'(len);
   endtask

   // Runs one burst whose command is being offered right now (at a falling
   // edge). mode: 0 ready held high, 1 ready toggles, 2 ready random.
   // nxt keeps the next command offered during the burst. abort_after>0
   // returns right before the edge that accepts that many beats.
   task automatic burst(input logic [11:0] addr, input int len, input int mode,
                        input bit nxt, input logic [11:0] naddr, input int nlen,
                        input int abort_after);
      logic [10:0] exp_q[$];
      logic [10:0] e;
      logic [11:0] a;
      logic [11:0] next_addr;
      int cyc = 0;
      int issued = 0;
      int popped = 0;
      int pending = 0;
      bit done_now;
      bit rd;

      chk("cmd_ready_at_offer", 32'(cmd_ready), 32'd1);
      for (int i = 0; i < len; i++) begin
         a = addr + 12'(i);
         exp_q.push_back({(i == len - 1), mem[a]});
      end
      next_addr = addr;

      while (1) begin
         @(negedge clk);
         cyc++;
         if (nxt) begin
            cmd_valid = 1'b1;
            cmd_addr  = naddr;
            cmd_len   = 12'(nlen);
         end else begin
            cmd_valid = 1'b0;
         end
         if (mode == 0)      m_ready = 1'b1;
         else if (mode == 1) m_ready = cyc[0];
         else                m_ready = 1'($urandom_range(0, 1));
         #1;

         done_now = (popped == len);
         chk("cmd_done", 32'(cmd_done), 32'(done_now));
         chk("cmd_ready", 32'(cmd_ready), 32'(done_now));
         chk("busy", 32'(busy), 32'(!done_now));
         chk("m_valid", 32'(m_valid), 32'(pending != 0));
         if (done_now) break;

         if (pending == 2) chk("no_issue_when_full", 32'(s_read_req), 32'd0);
         if (mode == 0 && cyc == 1) chk("first_issue", 32'(s_read_req), 32'd1);
         rd = s_read_req;
         if (rd) begin
            if (issued >= len) begin
               chk("extra_issue", 32'(s_read_req), 32'd0);
            end else begin
               chk("read_addr", 32'(s_read_addr), 32'(next_addr));
            end
            issued++;
            next_addr = next_addr + 12'd1;
         end

         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", 32'(m_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("m_data", 32'(m_data), 32'(e[9:0]));
               chk("m_last", 32'(m_last), 32'(e[10]));
               if (mode == 0) chk("beat_cycle", 32'(cyc), 32'(popped + 2));
            end
            popped++;
            pending--;
         end
         if (rd) pending++;

         if (abort_after > 0 && popped == abort_after) return;
         if (cyc > 400) begin
            chk("burst_timeout", 32'(popped), 32'(len));
            break;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"},  32'(cmd_ready),   32'd1);
      chk({tag, "_read_req"},   32'(s_read_req),  32'd0);
      chk({tag, "_read_addr"},  32'(s_read_addr), 32'd0);
      chk({tag, "_m_valid"},    32'(m_valid),     32'd0);
      chk({tag, "_m_last"},     32'(m_last),      32'd0);
      chk({tag, "_m_data"},     32'(m_data),      32'd0);
      chk({tag, "_busy"},       32'(busy),        32'd0);
      chk({tag, "_cmd_done"},   32'(cmd_done),    32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      m_ready   = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 10'(i);

      #3;
      check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Basic burst, consumer always ready.
      offer(12'h010, 4);
      burst(12'h010, 4, 0, 1'b0, 12'h0, 0, 0);

      // Address wrap at the top of the RAM.
      offer(12'hFFE, 4);
      burst(12'hFFE, 4, 0, 1'b0, 12'h0, 0, 0);

      // Backpressure with ready toggling every cycle.
      offer(12'h123, 6);
      burst(12'h123, 6, 1, 1'b0, 12'h0, 0, 0);

      // Zero-length command: done pulse only.
      offer(12'h055, 0);
      burst(12'h055, 0, 0, 1'b0, 12'h0, 0, 0);
      @(negedge clk);
      chk("len0_done_drops", 32'(cmd_done), 32'd0);
      chk("len0_no_valid", 32'(m_valid), 32'd0);
      chk("len0_ready_stays", 32'(cmd_ready), 32'd1);

      // Reset in the middle of a burst after three beats.
      offer(12'h300, 8);
      burst(12'h300, 8, 0, 1'b0, 12'h0, 0, 3);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_reset_no_done", 32'(cmd_done), 32'd0);
      chk("post_reset_idle", 32'(busy), 32'd0);
      offer(12'h040, 2);
      burst(12'h040, 2, 0, 1'b0, 12'h0, 0, 0);

      // Back-to-back: second command held throughout the first burst.
      offer(12'h020, 3);
      burst(12'h020, 3, 0, 1'b1, 12'h200, 5, 0);
      burst(12'h200, 5, 0, 1'b0, 12'h0, 0, 0);

      // Randomized contents, addresses, lengths and consumer stalls.
      for (int i = 0; i < 4096; i++) mem[i] = 10'($urandom);
      for (int t = 0; t < 6; t++) begin
         logic [11:0] ra;
         int rl;
         ra = 12'($urandom);
         rl = int'($urandom_range(1, 9));
         offer(ra, rl);
         burst(ra, rl, 2, 1'b0, 12'h0, 0, 0);
      end
      @(negedge clk);
      chk("final_done_drops", 32'(cmd_done), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
